axil_block_reader: RTL and testbench
====================================

# axil_block_reader

AXI4-Lite read-only master that fetches a block of consecutive 32-bit registers from a slave (e.g. the checker's status/error-data register file) and presents them as one wide, coherent snapshot. It sits between a local controller (or the optional poll timer) and the AXI interconnect. The snapshot layout matches the slave's error-data convention: the first word read occupies the most-significant 32 bits.

## Interface
- BASE_ADDR, 32'h0000_0040, byte address of first register read
- WORDS, 16, number of 32-bit registers per block (1..64)
- POLL_CYCLES, 100_000_000, clk cycles between automatic reads (used only with macro)
- clk  in  1  sole clock; all logic rising-edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to read the block
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse: snapshot committed
- resp_err  out  1  last block had ≥1 non-OKAY RRESP
- err_index  out  6  index of first failing word in last block
- rd_data  out  32*WORDS  committed snapshot
- M_AXI_ARADDR  out  32  read address
- M_AXI_ARVALID  out  1  address valid
- M_AXI_ARPROT  out  3  constant 0
- M_AXI_ARREADY  in  1  slave accepts address
- M_AXI_RDATA  in  32  read data
- M_AXI_RRESP  in  2  read response
- M_AXI_RVALID  in  1  data valid
- M_AXI_RREADY  out  1  master accepts data

## Operation
- States: IDLE, ADDR, DATA, COMMIT.
- IDLE: start=1 → index=0, clear shadow error flags, → ADDR. start while busy ignored.
- ADDR: ARVALID=1, ARADDR=BASE_ADDR+4*index, held stable until ARVALID&ARREADY → DATA.
- DATA: RREADY=1; on RVALID&RREADY store RDATA into shadow[(WORDS-1-index)*32 +: 32]; if RRESP≠OKAY and no prior error this block, latch err_index=index and set shadow error. If index==WORDS-1 → COMMIT, else index+1 → ADDR.
- COMMIT: copy shadow to rd_data, shadow error to resp_err/err_index, pulse done → IDLE.
- One outstanding read only; non-OKAY responses do not abort the block.
- rd_data, resp_err, err_index change only in COMMIT (coherent between done pulses).
- Reset values: ARVALID=0, RREADY=0, ARADDR=0, busy=0, done=0, resp_err=0, err_index=0, rd_data=0. Reset mid-block: all outputs return to reset values immediately (asynchronous); partial data discarded.

## Timing
- start sampled cycle 0 → ARVALID high cycle 1.
- RREADY asserted the cycle after AR handshake; next ARVALID the cycle after R handshake.
- Zero-wait slave: 2 cycles per word; done at cycle 2*WORDS+1, rd_data valid same cycle.
- busy high from cycle 1 through the COMMIT cycle inclusive.
- Back-pressure: ARVALID/ARADDR and RREADY held indefinitely; no timeout.
- start in the COMMIT cycle ignored; start first accepted in the following IDLE cycle.

## Configuration
- AXIL_BLOCK_READER_POLL_EN defined: free-running counter issues an internal start every POLL_CYCLES cycles, OR'd with start; a tick while busy is dropped (counter still reloads).
- Undefined: no counter; reads occur only on external start.

## Structure
- Shared package axil_pkg: RESP_OKAY=0, RESP_SLVERR=2, RESP_DECERR=3, state enum (IDLE/ADDR/DATA/COMMIT).
- One natural sub-module: axil_poll_timer (counter + tick), instantiated only under AXIL_BLOCK_READER_POLL_EN.

## Test plan
- WORDS=16, zero-wait slave returning 32'hA000_0000+index → done at cycle 33, rd_data[511:480]=32'hA000_0000, rd_data[31:0]=32'hA000_000F, resp_err=0.
- ARREADY delayed 5 cycles on word 3 → ARADDR held at BASE_ADDR+12, ARVALID stable, data unaffected, done at cycle 38.
- Slave returns DECERR on words 4 and 9 → resp_err=1, err_index=4, all 16 words still stored.
- start pulsed during busy → ignored; exactly one done, 16 AR handshakes.
- resetn low while in DATA on word 7 → ARVALID=RREADY=busy=0 same cycle, rd_data keeps 0; new start after reset completes normally.
- Macro defined, POLL_CYCLES=100 → done pulses every 100 cycles with zero-wait slave; no external start needed.

Source files
------------

// File: rtl/axil_pkg.sv
// -----------------------------------------------------------------------------
// axil_pkg
// Shared AXI4-Lite definitions for the block reader: response codes, the
// reader state encoding and the register-address helper.
// -----------------------------------------------------------------------------
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    COMMIT
  } state_t;

  // Byte address of 32-bit register 'idx' counted from 'base'.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [5:0] idx);
    return base + {24'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/axil_block_reader_if.sv
// -----------------------------------------------------------------------------
// axil_block_reader_if
// Read-only AXI4-Lite channel bundle (AR + R) used by the block reader.
//   master : drives ARADDR/ARVALID/ARPROT/RREADY, receives ARREADY/RDATA/RRESP/RVALID
//   slave  : the mirror image, for a slave model or interconnect port
// -----------------------------------------------------------------------------
interface axil_block_reader_if;

  logic [31:0] M_AXI_ARADDR;
  logic        M_AXI_ARVALID;
  logic [2:0]  M_AXI_ARPROT;
  logic        M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;

  modport master (
    output M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_ARPROT, M_AXI_RREADY,
    input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );

  modport slave (
    input  M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_ARPROT, M_AXI_RREADY,
    output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );

endinterface

// File: rtl/axil_poll_timer.sv
// -----------------------------------------------------------------------------
// axil_poll_timer
// Free-running counter that raises 'tick' for one cycle every CYCLES cycles.
//   clk    : clock
//   resetn : asynchronous active-low reset
//   tick   : one-cycle pulse, period CYCLES
// -----------------------------------------------------------------------------
module axil_poll_timer #(
  parameter int unsigned CYCLES = 100
) (
  input  logic clk,
  input  logic resetn,
  output logic tick
);

  localparam int unsigned     CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0]   LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: combinational blocks assign every output on every path (default
  // first), otherwise synthesis infers a latch.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (cnt_q == LAST) cnt_d = '0;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/axil_block_reader.sv
// -----------------------------------------------------------------------------
// axil_block_reader
// AXI4-Lite read master that fetches WORDS consecutive 32-bit registers from
// BASE_ADDR and publishes them as one coherent snapshot. The first register
// read lands in the most-significant 32 bits of rd_data.
//
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   start       : one-cycle read request (ignored while busy)
//   busy        : block transfer in progress (ADDR/DATA/COMMIT)
//   done        : one-cycle pulse, snapshot committed this cycle
//   resp_err    : last block saw at least one non-OKAY RRESP
//   err_index   : index of the first failing word in the last block
//   rd_data     : committed snapshot, 32*WORDS bits
//   m_axi       : AR/R channels (master modport)
//
// Build option: define AXIL_BLOCK_READER_POLL_EN to add an internal timer that
// requests a block every POLL_CYCLES cycles in addition to 'start'.
// -----------------------------------------------------------------------------
module axil_block_reader
  import axil_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0040,
  parameter int unsigned WORDS       = 16,
  parameter int unsigned POLL_CYCLES = 100_000_000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  resp_err,
  output logic [5:0]            err_index,
  output logic [32*WORDS-1:0]   rd_data,
  axil_block_reader_if.master   m_axi
);

  localparam logic [5:0]  LAST_IDX = 6'(WORDS - 1);
  localparam int unsigned IW       = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic start_req;

`ifdef AXIL_BLOCK_READER_POLL_EN
  logic poll_tick;

  axil_poll_timer #(.CYCLES(POLL_CYCLES)) u_poll_timer (
    .clk    (clk),
    .resetn (resetn),
    .tick   (poll_tick)
  );

  // A tick that lands while a block is in flight is simply not seen by IDLE.
  assign start_req = start | poll_tick;
`else
  logic unused_poll_cycles;
  assign unused_poll_cycles = ^POLL_CYCLES;
  assign start_req          = start;
`endif

  state_t                   state_q, state_d;
  logic [5:0]               index_q, index_d;
  logic [31:0]              araddr_q, araddr_d;
  logic                     arvalid_q, arvalid_d;
  logic                     rready_q, rready_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     resp_err_q, resp_err_d;
  logic [5:0]               err_index_q, err_index_d;
  logic [32*WORDS-1:0]      rd_data_q, rd_data_d;
  logic                     sh_err_q, sh_err_d;
  logic [5:0]               sh_idx_q, sh_idx_d;
  logic [WORDS-1:0][31:0]   shadow_q, shadow_d;
  logic [IW-1:0]            slot;

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    resp_err_d  = resp_err_q;
    err_index_d = err_index_q;
    rd_data_d   = rd_data_q;
    sh_err_d    = sh_err_q;
    sh_idx_d    = sh_idx_q;
    shadow_d    = shadow_q;
    // Word 0 goes to the top slot so the snapshot reads MSB-first.
    slot        = IW'(LAST_IDX - index_q);

    case (state_q)
      IDLE: begin
        if (start_req) begin
          index_d   = '0;
          sh_err_d  = 1'b0;
          sh_idx_d  = '0;
          araddr_d  = BASE_ADDR;
          arvalid_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (m_axi.M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (m_axi.M_AXI_RVALID) begin
          rready_d       = 1'b0;
          shadow_d[slot] = m_axi.M_AXI_RDATA;
          if (m_axi.M_AXI_RRESP != RESP_OKAY && !sh_err_q) begin
            sh_err_d = 1'b1;
            sh_idx_d = index_q;
          end
          if (index_q == LAST_IDX) begin
            // Published on entry so rd_data and done are both valid in COMMIT.
            rd_data_d   = shadow_d;
            resp_err_d  = sh_err_d;
            err_index_d = sh_idx_d;
            done_d      = 1'b1;
            state_d     = COMMIT;
          end else begin
            index_d   = index_q + 6'd1;
            araddr_d  = word_addr(BASE_ADDR, index_d);
            arvalid_d = 1'b1;
            state_d   = ADDR;
          end
        end
      end
      COMMIT: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      index_q     <= '0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      resp_err_q  <= 1'b0;
      err_index_q <= '0;
      rd_data_q   <= '0;
      sh_err_q    <= 1'b0;
      sh_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      resp_err_q  <= resp_err_d;
      err_index_q <= err_index_d;
      rd_data_q   <= rd_data_d;
      sh_err_q    <= sh_err_d;
      sh_idx_q    <= sh_idx_d;
    end
  end

  // NOTE: the shadow buffer has no reset: every slot is rewritten before it
  // can reach rd_data, so a reset would only cost routing and flop area.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign resp_err            = resp_err_q;
  assign err_index           = err_index_q;
  assign rd_data             = rd_data_q;
  assign m_axi.M_AXI_ARADDR  = araddr_q;
  assign m_axi.M_AXI_ARVALID = arvalid_q;
  assign m_axi.M_AXI_ARPROT  = 3'b000;
  assign m_axi.M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_block_reader.sv
// -----------------------------------------------------------------------------
// tb_axil_block_reader
// Self-checking bench for axil_block_reader (WORDS=16, BASE_ADDR=0x40).
// A behavioural AXI4-Lite slave returns salt+index per word with optional
// ARREADY stalls and error responses. Cycle 0 is the cycle in which start=1
// is sampled; outputs are observed on the falling edge.
// -----------------------------------------------------------------------------
module tb_axil_block_reader;
  import axil_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0040;
  localparam int          W    = 16;

  logic              clk    = 1'b0;
  logic              resetn = 1'b0;
  logic              start  = 1'b0;
  logic              busy, done, resp_err;
  logic [5:0]        err_index;
  logic [32*W-1:0]   rd_data;

  axil_block_reader_if axi ();

  axil_block_reader #(
    .BASE_ADDR   (BASE),
    .WORDS       (W),
    .POLL_CYCLES (100)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .resp_err  (resp_err),
    .err_index (err_index),
    .rd_data   (rd_data),
    .m_axi     (axi)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Slave configuration.
  int          dly_word   = -1;
  int          dly_cycles = 0;
  logic [63:0] err_mask   = '0;
  logic [1:0]  err_code   = RESP_DECERR;
  logic [31:0] salt       = 32'hA000_0000;
  int          ar_count   = 0;
  int          done_count = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [32*W-1:0] snap(input logic [31:0] s);
    logic [32*W-1:0] r;
    for (int i = 0; i < W; i++) r[(W-1-i)*32 +: 32] = s + 32'(i);
    return r;
  endfunction

  // Behavioural slave: decides at each falling edge what the DUT sees at the
  // next rising edge; handshakes are accounted one falling edge later.
  initial begin : slave
    bit         ar_fire, r_fire, r_pend;
    int         wait_cnt;
    logic [5:0] a_idx, r_idx;
    ar_fire = 0; r_fire = 0; r_pend = 0; wait_cnt = 0; a_idx = '0; r_idx = '0;
    axi.M_AXI_ARREADY = 1'b0;
    axi.M_AXI_RVALID  = 1'b0;
    axi.M_AXI_RDATA   = '0;
    axi.M_AXI_RRESP   = RESP_OKAY;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        axi.M_AXI_ARREADY = 1'b0;
        axi.M_AXI_RVALID  = 1'b0;
        ar_fire = 0; r_fire = 0; r_pend = 0; wait_cnt = 0;
      end else begin
        if (ar_fire) begin
          r_pend   = 1;
          r_idx    = a_idx;
          ar_count++;
          wait_cnt = 0;
        end
        if (r_fire) r_pend = 0;
        axi.M_AXI_RVALID = r_pend;
        axi.M_AXI_RDATA  = salt + 32'(r_idx);
        axi.M_AXI_RRESP  = err_mask[r_idx] ? err_code : RESP_OKAY;
        a_idx = 6'((axi.M_AXI_ARADDR - BASE) >> 2);
        if (axi.M_AXI_ARVALID && int'(a_idx) == dly_word && wait_cnt < dly_cycles) begin
          axi.M_AXI_ARREADY = 1'b0;
          wait_cnt++;
        end else begin
          axi.M_AXI_ARREADY = axi.M_AXI_ARVALID;
        end
        ar_fire = axi.M_AXI_ARVALID && axi.M_AXI_ARREADY;
        r_fire  = axi.M_AXI_RVALID && axi.M_AXI_RREADY;
      end
    end
  end

  initial begin : done_mon
    forever begin
      @(negedge clk);
      if (resetn && done) done_count++;
    end
  end

  typedef struct {
    string       name;
    int          dly_word;
    int          dly_cycles;
    logic [63:0] err_mask;
    logic [1:0]  err_code;
    logic [31:0] salt;
    int          exp_done;
    logic        exp_err;
    logic [5:0]  exp_idx;
  } vec_t;

  vec_t vecs[6];

  initial begin : main
    logic [32*W-1:0] prev_data;
    logic            prev_err;
    logic [5:0]      prev_idx;
    int              done_cyc, ar0, dn0, last, n;

    vecs[0] = '{"zero_wait",       -1, 0, 64'h0,                          RESP_DECERR, 32'hA000_0000, 33, 1'b0, 6'd0};
    vecs[1] = '{"decerr_4_9",      -1, 0, (64'h1 << 4) | (64'h1 << 9),    RESP_DECERR, 32'hB100_0000, 33, 1'b1, 6'd4};
    vecs[2] = '{"arready_wait_w3",  3, 5, 64'h0,                          RESP_DECERR, 32'hC200_0000, 38, 1'b0, 6'd0};
    vecs[3] = '{"slverr_w15_wait0", 0, 2, 64'h1 << 15,                    RESP_SLVERR, 32'hD300_0000, 35, 1'b1, 6'd15};
    vecs[4] = '{"decerr_w0_w15",   -1, 0, (64'h1 << 0) | (64'h1 << 15),   RESP_DECERR, 32'hE400_0000, 33, 1'b1, 6'd0};
    vecs[5] = '{"clean_after_err", -1, 0, 64'h0,                          RESP_DECERR, 32'h1234_5670, 33, 1'b0, 6'd0};

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_ctrl", {busy, done, resp_err, axi.M_AXI_ARVALID, axi.M_AXI_RREADY}, 5'b0);
    check("reset_araddr", axi.M_AXI_ARADDR, 32'h0);
    check("reset_arprot", axi.M_AXI_ARPROT, 3'b0);
    check("reset_err_index", err_index, 6'd0);
    check("reset_rd_data", rd_data, '0);
    #1 resetn = 1'b1;

`ifdef AXIL_BLOCK_READER_POLL_EN
    // Poll mode: blocks are launched by the internal timer only.
    last = -1;
    n    = 0;
    for (int c = 0; c < 460; c++) begin
      tick();
      if (done) begin
        n++;
        if (last >= 0) check("poll_interval", cyc - last, 100);
        else           check("poll_first_snapshot", rd_data, snap(32'hA000_0000));
        last = cyc;
      end
    end
    check("poll_done_count", n, 4);
`else
    // Reset in the middle of word 7: everything drops at once, no snapshot.
    @(negedge clk);
    salt  = 32'h5555_0000;
    start = 1'b1;
    cyc   = 0;
    tick();
    start = 1'b0;
    while (cyc < 16) tick();
    check("rst_mid_in_data_w7", {axi.M_AXI_ARVALID, axi.M_AXI_RREADY, axi.M_AXI_ARADDR}, {1'b0, 1'b1, BASE + 32'd28});
    #1 resetn = 1'b0;
    #1;
    check("rst_mid_ctrl", {axi.M_AXI_ARVALID, axi.M_AXI_RREADY, busy, done}, 4'b0);
    check("rst_mid_araddr", axi.M_AXI_ARADDR, 32'h0);
    check("rst_mid_rd_data", rd_data, '0);
    repeat (2) @(negedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);

    // Table of block reads.
    prev_data = '0;
    prev_err  = 1'b0;
    prev_idx  = '0;
    foreach (vecs[k]) begin
      dly_word   = vecs[k].dly_word;
      dly_cycles = vecs[k].dly_cycles;
      err_mask   = vecs[k].err_mask;
      err_code   = vecs[k].err_code;
      salt       = vecs[k].salt;
      ar0        = ar_count;
      dn0        = done_count;
      done_cyc   = -1;
      start      = 1'b1;
      cyc        = 0;
      for (int c = 0; c < 200; c++) begin
        tick();
        if (cyc == 1) begin
          start = 1'b0;
          check($sformatf("%s.first_ar", vecs[k].name),
                {busy, axi.M_AXI_ARVALID, axi.M_AXI_ARADDR}, {1'b1, 1'b1, BASE});
        end
        if (cyc == 10)
          check($sformatf("%s.coherent_mid", vecs[k].name),
                {rd_data, resp_err, err_index}, {prev_data, prev_err, prev_idx});
        if (vecs[k].dly_word >= 0 && cyc >= 2*vecs[k].dly_word + 1 &&
            cyc <= 2*vecs[k].dly_word + 1 + vecs[k].dly_cycles)
          check($sformatf("%s.ar_hold_c%0d", vecs[k].name, cyc),
                {axi.M_AXI_ARVALID, axi.M_AXI_RREADY, axi.M_AXI_ARADDR},
                {1'b1, 1'b0, BASE + 32'(4*vecs[k].dly_word)});
        if (done) begin
          done_cyc = cyc;
          break;
        end
      end
      check($sformatf("%s.done_cycle", vecs[k].name), done_cyc, vecs[k].exp_done);
      check($sformatf("%s.rd_data", vecs[k].name), rd_data, snap(vecs[k].salt));
      check($sformatf("%s.resp_err", vecs[k].name), resp_err, vecs[k].exp_err);
      check($sformatf("%s.err_index", vecs[k].name), err_index, vecs[k].exp_idx);
      check($sformatf("%s.busy_at_done", vecs[k].name), busy, 1'b1);
      check($sformatf("%s.ar_handshakes", vecs[k].name), ar_count - ar0, W);
      if (k == 0) begin
        check("zero_wait.msw", rd_data[511:480], 32'hA000_0000);
        check("zero_wait.lsw", rd_data[31:0], 32'hA000_000F);
      end
      tick();
      check($sformatf("%s.idle_after", vecs[k].name), {busy, done}, 2'b00);
      check($sformatf("%s.done_pulses", vecs[k].name), done_count - dn0, 1);
      prev_data = snap(vecs[k].salt);
      prev_err  = vecs[k].exp_err;
      prev_idx  = vecs[k].exp_idx;
    end

    // start while busy and in the COMMIT cycle is ignored.
    dly_word = -1;
    err_mask = '0;
    salt     = 32'hF000_0000;
    ar0      = ar_count;
    dn0      = done_count;
    done_cyc = -1;
    start    = 1'b1;
    cyc      = 0;
    for (int c = 0; c < 70; c++) begin
      tick();
      start = (cyc == 5) || (done_cyc < 0 && done);
      if (done && done_cyc < 0) done_cyc = cyc;
      if (done_cyc >= 0 && cyc == done_cyc + 1)
        check("start_in_commit.idle", busy, 1'b0);
    end
    start = 1'b0;
    check("start_busy.done_cycle", done_cyc, 33);
    check("start_busy.done_pulses", done_count - dn0, 1);
    check("start_busy.ar_handshakes", ar_count - ar0, W);
    check("start_busy.rd_data", rd_data, snap(32'hF000_0000));
    check("start_busy.idle_end", busy, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
